gas_alarm_ctrl: RTL and testbench

- Downstream consumer of the registered, active-high toxic-gas detect level `gas_signal`.
- Confirms a sustained detection, then raises a latched alarm that drives the buzzer and LED.
- Supports operator acknowledge (silence) and auto-clear after gas has been absent for a hold time.
- Counts confirmed alarm events for the display/telemetry path.

---
 rtl/gas_alarm_pkg.sv | 34 +++
 rtl/alarm_blink_gen.sv | 42 ++++
 rtl/gas_alarm_ctrl.sv | 172 +++++++++++++++++
 tb/tb_gas_alarm_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gas_alarm_pkg.sv
// Shared state encoding, default timing constants and small helpers for the gas alarm controller.
package gas_alarm_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CONFIRM  = 3'd1;
    localparam logic [2:0] ST_ALARM    = 3'd2;
    localparam logic [2:0] ST_SILENCED = 3'd3;
    localparam logic [2:0] ST_CLEAR    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_CONFIRM  = ST_CONFIRM,
        S_ALARM    = ST_ALARM,
        S_SILENCED = ST_SILENCED,
        S_CLEAR    = ST_CLEAR
    } gas_state_e;

    localparam int unsigned DEF_CONFIRM_CYC = 25_000_000;
    localparam int unsigned DEF_CLEAR_CYC   = 100_000_000;
    localparam int unsigned DEF_BEEP_HALF   = 12_500_000;
    localparam int          DEF_CNT_W       = 8;

    function automatic logic state_is_active(input gas_state_e s);
        return (s == S_ALARM) || (s == S_SILENCED) || (s == S_CLEAR);
    endfunction

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/alarm_blink_gen.sv
// Free-running BEEP_HALF cycle divider; tgl_o pulses on the cycle the count wraps.
// Synchronous active-high reset; clr_i restarts the period, en_i advances it.
module alarm_blink_gen
    import gas_alarm_pkg::*;
#(
    parameter int unsigned BEEP_HALF = DEF_BEEP_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tgl_o
);

    localparam int unsigned    CW   = cnt_width(BEEP_HALF - 1);
    localparam logic [CW-1:0]  LAST = CW'(BEEP_HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap  = (cnt_q == LAST);
    assign tgl_o = en_i & ~clr_i & wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gas_alarm_ctrl.sv
// Gas alarm controller: confirm sustained detection, latch alarm, drive buzzer/LED, count events.
// Optional GAS_ALARM_LATCH_EN: alarm must be acknowledged before it is allowed to auto-clear.
module gas_alarm_ctrl
    import gas_alarm_pkg::*;
#(
    parameter int unsigned CONFIRM_CYC = DEF_CONFIRM_CYC,
    parameter int unsigned CLEAR_CYC   = DEF_CLEAR_CYC,
    parameter int unsigned BEEP_HALF   = DEF_BEEP_HALF,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gas_signal,
    input  logic             alarm_ack,
    output logic             alarm_active,
    output logic             alarm_pulse,
    output logic             buzzer,
    output logic             led,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int unsigned       TMR_MAX   = (CONFIRM_CYC > CLEAR_CYC) ? CONFIRM_CYC : CLEAR_CYC;
    localparam int unsigned       TMR_W     = cnt_width(TMR_MAX);
    localparam logic [TMR_W-1:0]  CONF_LAST = TMR_W'(CONFIRM_CYC - 1);
    localparam logic [TMR_W-1:0]  CLR_LAST  = TMR_W'(CLEAR_CYC - 1);

    gas_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             confirm_hit;
    logic             state_chg;

    logic             phase_q, phase_d;
    logic             blink_en;
    logic             blink_tgl;

    logic             active_q, active_d;
    logic             pulse_q, pulse_d;
    logic             buzzer_q, buzzer_d;
    logic             led_q, led_d;
    logic [CNT_W-1:0] evt_q, evt_d;

    always_comb begin
        state_d     = state_q;
        tmr_d       = '0;
        confirm_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gas_signal) begin
                    if (CONFIRM_CYC == 1) begin
                        state_d     = S_ALARM;
                        confirm_hit = 1'b1;
                    end else begin
                        state_d = S_CONFIRM;
                        tmr_d   = TMR_W'(1);
                    end
                end
            end
            S_CONFIRM: begin
                if (!gas_signal) begin
                    state_d = S_IDLE;
                end else if (tmr_q == CONF_LAST) begin
                    state_d     = S_ALARM;
                    confirm_hit = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_ALARM: begin
`ifdef GAS_ALARM_LATCH_EN
                if (alarm_ack) begin
                    state_d = S_SILENCED;
                end
`else
                // Gas going away outranks a same-cycle acknowledge.
                if (!gas_signal) begin
                    state_d = S_CLEAR;
                end else if (alarm_ack) begin
                    state_d = S_SILENCED;
                end
`endif
            end
            S_SILENCED: begin
                if (!gas_signal) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (gas_signal) begin
`ifdef GAS_ALARM_LATCH_EN
                    state_d = S_SILENCED;
`else
                    state_d = S_ALARM;
`endif
                end else if (tmr_q == CLR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state_chg = (state_d != state_q);
    assign blink_en  = (state_q == S_ALARM) || (state_q == S_CLEAR);

    alarm_blink_gen #(
        .BEEP_HALF (BEEP_HALF)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_chg),
        .en_i  (blink_en),
        .tgl_o (blink_tgl)
    );

    // Blink phase restarts on every state entry: high for ALARM, low for CLEAR.
    always_comb begin
        phase_d = phase_q;
        if (state_chg) begin
            phase_d = (state_d == S_ALARM);
        end else if (blink_tgl) begin
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        active_d = state_is_active(state_d);
        pulse_d  = confirm_hit;
        buzzer_d = (state_d == S_ALARM) & phase_d;
        case (state_d)
            S_ALARM, S_CLEAR: led_d = phase_d;
            S_SILENCED:       led_d = 1'b1;
            default:          led_d = 1'b0;
        endcase
        evt_d = evt_q;
        if (confirm_hit && (evt_q != {CNT_W{1'b1}})) begin
            evt_d = evt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            phase_q  <= 1'b0;
            active_q <= 1'b0;
            pulse_q  <= 1'b0;
            buzzer_q <= 1'b0;
            led_q    <= 1'b0;
            evt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            phase_q  <= phase_d;
            active_q <= active_d;
            pulse_q  <= pulse_d;
            buzzer_q <= buzzer_d;
            led_q    <= led_d;
            evt_q    <= evt_d;
        end
    end

    assign alarm_active = active_q;
    assign alarm_pulse  = pulse_q;
    assign buzzer       = buzzer_q;
    assign led          = led_q;
    assign event_cnt    = evt_q;

endmodule

// File: tb/tb_gas_alarm_ctrl.sv
// Directed and randomized checks of gas_alarm_ctrl against a run-length based reference model.
module tb_gas_alarm_ctrl;

    localparam int CONFIRM = 4;
    localparam int CLEARC  = 8;
    localparam int BH      = 2;
    localparam int CW      = 3;
    localparam int EMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gas_signal = 1'b0;
    logic          alarm_ack = 1'b0;
    logic          alarm_active;
    logic          alarm_pulse;
    logic          buzzer;
    logic          led;
    logic [CW-1:0] event_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gas_alarm_ctrl #(
        .CONFIRM_CYC (CONFIRM),
        .CLEAR_CYC   (CLEARC),
        .BEEP_HALF   (BH),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gas_signal   (gas_signal),
        .alarm_ack    (alarm_ack),
        .alarm_active (alarm_active),
        .alarm_pulse  (alarm_pulse),
        .buzzer       (buzzer),
        .led          (led),
        .event_cnt    (event_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: alarm condition derived from run lengths and elapsed-time counters.
    bit m_act, m_sil, m_clr, m_pulse;
    int m_hi, m_t, m_ct, m_evt;

    task automatic model_step(input bit g, input bit a, input bit r);
        m_pulse = 0;
        if (r) begin
            m_act = 0; m_sil = 0; m_clr = 0;
            m_hi = 0; m_t = 0; m_ct = 0; m_evt = 0;
            return;
        end
        m_hi = g ? m_hi + 1 : 0;
        if (!m_act) begin
            if (m_hi >= CONFIRM) begin
                m_act = 1; m_sil = 0; m_clr = 0; m_t = 0; m_pulse = 1;
                if (m_evt < EMAX) m_evt++;
            end
        end else if (m_clr) begin
            if (g) begin
                m_clr = 0; m_t = 0;
`ifdef GAS_ALARM_LATCH_EN
                m_sil = 1;
`else
                m_sil = 0;
`endif
            end else begin
                // The sample entering clearing is count zero; idle after CLEARC further lows.
                m_ct++;
                if (m_ct == CLEARC) begin
                    m_act = 0; m_clr = 0; m_sil = 0;
                end
            end
        end else if (m_sil) begin
            if (!g) begin
                m_clr = 1; m_ct = 0;
            end
        end else begin
`ifdef GAS_ALARM_LATCH_EN
            if (a) m_sil = 1;
            else   m_t++;
`else
            if (!g) begin
                m_clr = 1; m_ct = 0;
            end else if (a) begin
                m_sil = 1;
            end else begin
                m_t++;
            end
`endif
        end
    endtask

    task automatic step(input bit g, input bit a, input bit r);
        bit e_bz, e_led;
        gas_signal = g;
        alarm_ack  = a;
        rst        = r;
        @(posedge clk);
        #1;
        model_step(g, a, r);
        e_bz  = m_act && !m_sil && !m_clr && (((m_t / BH) % 2) == 0);
        e_led = !m_act ? 1'b0 : m_clr ? bit'((m_ct / BH) % 2) : m_sil ? 1'b1 : e_bz;
        check("active", alarm_active, m_act);
        check("pulse",  alarm_pulse,  m_pulse);
        check("buzzer", buzzer,       e_bz);
        check("led",    led,          e_led);
        check("evt",    event_cnt,    m_evt);
    endtask

    task automatic confirm_alarm();
        for (int i = 0; i < CONFIRM; i++) step(1, 0, 0);
    endtask

    task automatic go_idle();
`ifdef GAS_ALARM_LATCH_EN
        if (m_act && !m_sil && !m_clr) step(1, 1, 0);
`endif
        for (int i = 0; i < CLEARC + 1; i++) step(0, 0, 0);
    endtask

    initial begin
        logic [5:0] bz_pat;
        logic [3:0] led_pat;
        bz_pat  = 6'b110011;
        led_pat = 4'b0011;

        step(0, 0, 1);
        step(0, 0, 1);
        check("rst_evt", event_cnt, 0);
        check("rst_led", led, 0);

        // Glitch: 3 high, 1 low, 3 high must not confirm.
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(0, 0, 0);
        check("glitch_active", alarm_active, 0);
        check("glitch_evt", event_cnt, 0);

        // Confirm on the 4th high sample, then buzzer blink pattern.
        for (int i = 0; i < CONFIRM - 1; i++) step(1, 0, 0);
        check("pre_confirm", alarm_active, 0);
        step(1, 0, 0);
        check("confirm_pulse", alarm_pulse, 1);
        check("confirm_evt", event_cnt, 1);
        check("bz_pat0", buzzer, bz_pat[5]);
        for (int i = 1; i < 6; i++) begin
            step(1, 0, 0);
            check("bz_pat", buzzer, bz_pat[5-i]);
        end
        check("pulse_once", alarm_pulse, 0);

        // Acknowledge silences, gas drop enters clearing blink, then idle.
        step(1, 1, 0);
        check("sil_buzzer", buzzer, 0);
        check("sil_led", led, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            check("clr_led", led, led_pat[3-i]);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check("clr_hold", alarm_active, 1);
        step(0, 0, 0);
        check("clr_idle", alarm_active, 0);
        check("clr_idle_led", led, 0);

        // Re-assert during clearing: back to alarm with no new event.
        confirm_alarm();
`ifdef GAS_ALARM_LATCH_EN
        step(1, 1, 0);
`endif
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        step(1, 0, 0);
        check("reassert_pulse", alarm_pulse, 0);
        check("reassert_evt", event_cnt, 2);
`ifndef GAS_ALARM_LATCH_EN
        check("reassert_buzzer", buzzer, 1);
`endif
        go_idle();

        // Ack and gas drop in the same alarm cycle.
        confirm_alarm();
        step(0, 1, 0);
        check("simul_active", alarm_active, 1);
`ifndef GAS_ALARM_LATCH_EN
        check("simul_led", led, 0);
        check("simul_buzzer", buzzer, 0);
`endif
        go_idle();

`ifdef GAS_ALARM_LATCH_EN
        confirm_alarm();
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check("latch_hold", alarm_active, 1);
        go_idle();
`endif

        // Saturation after a clean reset.
        step(0, 0, 1);
        for (int n = 0; n < 9; n++) begin
            confirm_alarm();
            go_idle();
        end
        check("sat_evt", event_cnt, EMAX);

        // Reset in the middle of an alarm.
        confirm_alarm();
        step(1, 0, 1);
        check("rst_mid_active", alarm_active, 0);
        check("rst_mid_buzzer", buzzer, 0);
        check("rst_mid_led", led, 0);
        check("rst_mid_evt", event_cnt, 0);
        step(1, 0, 0);
        check("rst_mid_after", event_cnt, 0);

        // Randomized runs of gas level with sporadic acks and resets.
        for (int n = 0; n < 600; n++) begin
            bit lvl;
            int len;
            lvl = bit'($urandom_range(0, 1));
            len = $urandom_range(1, 13);
            for (int k = 0; k < len; k++) begin
                step(lvl, ($urandom_range(0, 7) == 0), ($urandom_range(0, 499) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
